// File: rtl/fpu_dispatch_if.sv
// ----------------------------------------------------------------------------
// fpu_dispatch_if
// Handshake bundle between the instruction front end, fpu_dispatch and the
// result consumer.
//   in_valid/in_ready   : operation offer / accept
//   in_op, in_a, in_b   : op code (00 add, 01 sub, 10 mul, 11 div) and FP32 operands
//   in_tag              : user tag carried through to the result
//   out_valid/out_ready : head result offer / consume
//   out_result, out_tag, out_op : head entry contents (0 when out_valid=0)
//   busy                : ROB holds at least one entry
// Modports: master = front end / consumer side, slave = fpu_dispatch side.
// ----------------------------------------------------------------------------
interface fpu_dispatch_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       out_op;
    logic             busy;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_op, busy
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_op, busy
    );
endinterface

// File: rtl/fpu_dispatch.sv
// ----------------------------------------------------------------------------
// fpu_dispatch
// Issues tagged FP32 operations to add/sub/mul/div units in the accept cycle
// and retires results strictly in issue order through a DEPTH-entry reorder
// buffer with output backpressure.
// Ports:
//   clk    : clock, all state on rising edge
//   reset  : asynchronous active-low reset
//   io     : fpu_dispatch_if.slave (input offer, head result, busy)
//   stall_cnt, retire_cnt : saturating 16-bit statistics, present only when
//            FPU_DISPATCH_STATS_EN is defined
// Arithmetic: normal numbers with round-to-nearest-even; zero/denormal inputs
// are treated as zero, overflow gives infinity, underflow flushes to zero.
// Unit latencies: add 1, sub 1, mul 2, div 4 cycles.
// ----------------------------------------------------------------------------
package fpu_dispatch_pkg;

    // m holds the significand with the leading 1 at bit 26, then guard,
    // round and sticky bits.
    function automatic logic [31:0] fp_pack(input logic s, input int e, input logic [26:0] m);
        logic [24:0] r;
        int          ex;
        ex = e;
        r  = {1'b0, m[26:3]};
        if (m[2] && (m[1] || m[0] || m[3])) r = r + 25'd1;
        if (r[24]) begin
            r  = r >> 1;
            ex = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 23'd0};
        if (ex <= 0)   return {s, 31'd0};
        return {s, ex[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [26:0] mx, my, lost;
        logic [27:0] s;
        int          d, e;
        if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? 32'd0 : b;
        if (b[30:23] == 8'd0) return a;
        // x is the larger magnitude, so the result takes its sign
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else                    begin x = b; y = a; end
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        d  = int'(x[30:23]) - int'(y[30:23]);
        if (d > 26) my = 27'd1;
        else begin
            lost = my & ((27'd1 << d) - 27'd1);
            my   = (my >> d) | {26'd0, |lost};
        end
        e = int'(x[30:23]);
        if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s = {1'b0, s[27:2], s[1] | s[0]};
                e = e + 1;
            end
        end else begin
            s = {1'b0, mx} - {1'b0, my};
            if (s == 28'd0) return 32'd0;
            for (int i = 0; i < 26; i++) begin
                if (!s[26]) begin
                    s = s << 1;
                    e = e - 1;
                end
            end
        end
        return fp_pack(x[31], e, s[26:0]);
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [26:0] m;
        int          e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = {p[47:22], p[21] | (|p[20:0])};
            e = e + 1;
        end else begin
            m = {p[46:21], p[20] | (|p[19:0])};
        end
        return fp_pack(a[31] ^ b[31], e, m);
    endfunction

    function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
        logic [50:0] n, den;
        logic [27:0] q;
        logic [23:0] r;
        logic [26:0] m;
        logic        s;
        int          e;
        s = a[31] ^ b[31];
        if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
        if (a[30:23] == 8'd0) return {s, 31'd0};
        n   = {1'b1, a[22:0], 27'd0};
        den = {27'd0, 1'b1, b[22:0]};
        q   = 28'(n / den);
        r   = 24'(n % den);
        e   = int'(a[30:23]) - int'(b[30:23]) + 127;
        // quotient lies in [2^26, 2^28): bit 27 set means ratio >= 1
        if (q[27]) m = {q[27:2], q[1] | q[0] | (r != 24'd0)};
        else begin
            m = {q[26:1], q[0] | (r != 24'd0)};
            e = e - 1;
        end
        return fp_pack(s, e, m);
    endfunction

endpackage

// Fixed-latency delay line: one valid_i yields one ready_o LAT cycles later.
module fpu_pipe #(
    parameter int LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic [31:0] res_i,
    output logic        ready_o,
    output logic [31:0] result_o
);
    logic [LAT-1:0] vld_q;
    logic [31:0]    dat_q [LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vld_q <= '0;
        else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // NOTE: data stages carry no reset; only the valid bits qualify them,
    // so resetting the payload would add fan-out without changing behaviour.
    always_ff @(posedge clk) begin
        dat_q[0] <= res_i;
        for (int i = 1; i < LAT; i++) dat_q[i] <= dat_q[i-1];
    end

    assign ready_o  = vld_q[LAT-1];
    assign result_o = dat_q[LAT-1];
endmodule

module fpu_add #(parameter int LAT = 1) (
    input  logic clk, input logic reset, input logic valid_i,
    input  logic [31:0] a_i, input logic [31:0] b_i,
    output logic ready_o, output logic [31:0] result_o
);
    logic [31:0] res;
    assign res = fpu_dispatch_pkg::fp_add(a_i, b_i);
    fpu_pipe #(.LAT(LAT)) u_pipe (.clk(clk), .reset(reset), .valid_i(valid_i), .res_i(res),
                                  .ready_o(ready_o), .result_o(result_o));
endmodule

module fpu_sub #(parameter int LAT = 1) (
    input  logic clk, input logic reset, input logic valid_i,
    input  logic [31:0] a_i, input logic [31:0] b_i,
    output logic ready_o, output logic [31:0] result_o
);
    logic [31:0] res;
    assign res = fpu_dispatch_pkg::fp_add(a_i, {~b_i[31], b_i[30:0]});
    fpu_pipe #(.LAT(LAT)) u_pipe (.clk(clk), .reset(reset), .valid_i(valid_i), .res_i(res),
                                  .ready_o(ready_o), .result_o(result_o));
endmodule

module fpu_mul #(parameter int LAT = 2) (
    input  logic clk, input logic reset, input logic valid_i,
    input  logic [31:0] a_i, input logic [31:0] b_i,
    output logic ready_o, output logic [31:0] result_o
);
    logic [31:0] res;
    assign res = fpu_dispatch_pkg::fp_mul(a_i, b_i);
    fpu_pipe #(.LAT(LAT)) u_pipe (.clk(clk), .reset(reset), .valid_i(valid_i), .res_i(res),
                                  .ready_o(ready_o), .result_o(result_o));
endmodule

module fpu_div #(parameter int LAT = 4) (
    input  logic clk, input logic reset, input logic valid_i,
    input  logic [31:0] a_i, input logic [31:0] b_i,
    output logic ready_o, output logic [31:0] result_o
);
    logic [31:0] res;
    assign res = fpu_dispatch_pkg::fp_div(a_i, b_i);
    fpu_pipe #(.LAT(LAT)) u_pipe (.clk(clk), .reset(reset), .valid_i(valid_i), .res_i(res),
                                  .ready_o(ready_o), .result_o(result_o));
endmodule

module fpu_dispatch #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic clk,
    input  logic reset,
    fpu_dispatch_if.slave io
`ifdef FPU_DISPATCH_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] retire_cnt
`endif
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NU    = 4;

    logic [CNT_W-1:0] count_q;
    logic [IDX_W-1:0] head_q, tail_q;
    logic [DEPTH-1:0] done_q, done_d;
    logic [31:0]      res_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [1:0]       op_q  [DEPTH];

    // Per-unit FIFOs of ROB indices; units finish in order, so the oldest
    // index in a unit's FIFO is the entry its next result belongs to.
    logic [IDX_W-1:0] fifo_q [NU][DEPTH];
    logic [IDX_W-1:0] frd_q  [NU];
    logic [IDX_W-1:0] fwr_q  [NU];
    logic [CNT_W-1:0] fcnt_q [NU];

    logic [NU-1:0]    u_valid, u_ready, pop;
    logic [31:0]      u_res   [NU];
    logic [IDX_W-1:0] pop_idx [NU];
    logic             accept, retire;

    assign io.in_ready = (count_q < CNT_W'(DEPTH));
    assign accept      = io.in_valid & io.in_ready;
    assign u_valid     = accept ? (NU'(1) << io.in_op) : '0;

    assign io.busy      = (count_q != '0);
    assign io.out_valid = done_q[head_q] & io.busy;
    assign retire       = io.out_valid & io.out_ready;
    assign io.out_result = io.out_valid ? res_q[head_q] : '0;
    assign io.out_tag    = io.out_valid ? tag_q[head_q] : '0;
    assign io.out_op     = io.out_valid ? op_q[head_q]  : '0;

    fpu_add #(.LAT(1)) u_add (.clk(clk), .reset(reset), .valid_i(u_valid[0]), .a_i(io.in_a),
                              .b_i(io.in_b), .ready_o(u_ready[0]), .result_o(u_res[0]));
    fpu_sub #(.LAT(1)) u_sub (.clk(clk), .reset(reset), .valid_i(u_valid[1]), .a_i(io.in_a),
                              .b_i(io.in_b), .ready_o(u_ready[1]), .result_o(u_res[1]));
    fpu_mul #(.LAT(2)) u_mul (.clk(clk), .reset(reset), .valid_i(u_valid[2]), .a_i(io.in_a),
                              .b_i(io.in_b), .ready_o(u_ready[2]), .result_o(u_res[2]));
    fpu_div #(.LAT(4)) u_div (.clk(clk), .reset(reset), .valid_i(u_valid[3]), .a_i(io.in_a),
                              .b_i(io.in_b), .ready_o(u_ready[3]), .result_o(u_res[3]));

    // A ready with an empty index FIFO is a protocol error and is dropped.
    always_comb begin
        for (int u = 0; u < NU; u++) begin
            pop[u]     = u_ready[u] & (fcnt_q[u] != '0);
            pop_idx[u] = fifo_q[u][frd_q[u]];
        end
    end

    // NOTE: combinational next-state uses blocking assignments with the
    // default (hold) assigned first, so no path can infer a latch.
    // Completions, the retiring head and the newly written tail are always
    // distinct entries, so the update order below never loses a write.
    always_comb begin
        done_d = done_q;
        for (int u = 0; u < NU; u++) begin
            if (pop[u]) done_d[pop_idx[u]] = 1'b1;
        end
        if (retire) done_d[head_q] = 1'b0;
        if (accept) done_d[tail_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            done_q  <= '0;
            for (int u = 0; u < NU; u++) begin
                frd_q[u]  <= '0;
                fwr_q[u]  <= '0;
                fcnt_q[u] <= '0;
            end
        end else begin
            done_q <= done_d;
            // DEPTH is a power of two, so pointer overflow is the wrap.
            if (accept) tail_q <= tail_q + 1'b1;
            if (retire) head_q <= head_q + 1'b1;
            case ({accept, retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            for (int u = 0; u < NU; u++) begin
                if (u_valid[u]) fwr_q[u] <= fwr_q[u] + 1'b1;
                if (pop[u])     frd_q[u] <= frd_q[u] + 1'b1;
                case ({u_valid[u], pop[u]})
                    2'b10:   fcnt_q[u] <= fcnt_q[u] + 1'b1;
                    2'b01:   fcnt_q[u] <= fcnt_q[u] - 1'b1;
                    default: fcnt_q[u] <= fcnt_q[u];
                endcase
            end
        end
    end

    // Payload storage: qualified by done bits and FIFO counts.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q[tail_q] <= io.in_tag;
            op_q[tail_q]  <= io.in_op;
        end
        for (int u = 0; u < NU; u++) begin
            if (u_valid[u]) fifo_q[u][fwr_q[u]] <= tail_q;
            if (pop[u])     res_q[pop_idx[u]]   <= u_res[u];
        end
    end

`ifdef FPU_DISPATCH_STATS_EN
    logic [15:0] stall_q, retire_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            retire_q <= '0;
        end else begin
            if (io.in_valid && !io.in_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
            if (retire && retire_q != 16'hFFFF) retire_q <= retire_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_q;
    assign retire_cnt = retire_q;
`endif
endmodule

// File: tb/tb_fpu_dispatch.sv
// ----------------------------------------------------------------------------
// tb_fpu_dispatch
// Directed bench for fpu_dispatch (DEPTH=4, TAG_W=4). Inputs change 2 time
// units after a rising edge; outputs are sampled on the falling edge. A
// monitor records every retired beat; each scenario task compares the
// recorded beats and status outputs against hand-computed FP32 values.
// ----------------------------------------------------------------------------
module tb_fpu_dispatch;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [1:0]  op;
    } beat_t;

    beat_t got_q[$];

    fpu_dispatch_if #(.TAG_W(4)) io ();

`ifdef FPU_DISPATCH_STATS_EN
    logic [15:0] stall_cnt, retire_cnt;
`endif

    fpu_dispatch #(.DEPTH(4), .TAG_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .io(io)
`ifdef FPU_DISPATCH_STATS_EN
        ,
        .stall_cnt(stall_cnt),
        .retire_cnt(retire_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (io.out_valid === 1'b1 && io.out_ready === 1'b1)
            got_q.push_back({io.out_result, io.out_tag, io.out_op});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Offers one operation and returns once it has been accepted.
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        int n;
        bit fired;
        n = 0;
        fired = 0;
        io.in_valid = 1'b1;
        io.in_op = op;
        io.in_a = a;
        io.in_b = b;
        io.in_tag = tag;
        while (!fired) begin
            @(negedge clk);
            if (io.in_ready === 1'b1) fired = 1;
            else if (++n > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: in_ready got %b want 1 within 200 cycles", io.in_ready);
                fired = 1;
            end
            tick();
        end
        io.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string name);
        int k;
        k = 0;
        while (got_q.size() < n && k < 300) begin
            tick();
            k++;
        end
        vectors++;
        if (got_q.size() < n) begin
            miscompares++;
            $display("FAIL %s_count: beats got %0d want %0d", name, got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) tick();
        sample();
        vectors += 6;
        if (io.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", io.in_ready); end
        if (io.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b want 0", io.out_valid); end
        if (io.out_result !== 32'd0) begin miscompares++; $display("FAIL rst_out_result got %h want 0", io.out_result); end
        if (io.out_tag !== 4'd0) begin miscompares++; $display("FAIL rst_out_tag got %h want 0", io.out_tag); end
        if (io.out_op !== 2'd0) begin miscompares++; $display("FAIL rst_out_op got %h want 0", io.out_op); end
        if (io.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %b want 0", io.busy); end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_add();
        got_q.delete();
        io.out_ready = 1'b1;
        send(2'b00, 32'h3F800000, 32'h40000000, 4'd3);
        wait_results(1, "single");
        repeat (5) tick();
        vectors += 5;
        if (got_q.size() !== 1) begin miscompares++; $display("FAIL single_beats got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            if (got_q[0].res !== 32'h40400000) begin miscompares++; $display("FAIL single_res got %h want 40400000", got_q[0].res); end
            if (got_q[0].tag !== 4'd3) begin miscompares++; $display("FAIL single_tag got %h want 3", got_q[0].tag); end
            if (got_q[0].op !== 2'b00) begin miscompares++; $display("FAIL single_op got %b want 00", got_q[0].op); end
        end else begin
            miscompares += 3;
            $display("FAIL single_fields got none want one beat");
        end
        sample();
        if (io.busy !== 1'b0) begin miscompares++; $display("FAIL single_busy got %b want 0", io.busy); end
        tick();
    endtask

    task automatic test_each_op();
        logic [31:0] er [3] = '{32'h40800000, 32'h40C00000, 32'h40000000};
        logic [1:0]  eo [3] = '{2'b01, 2'b10, 2'b11};
        got_q.delete();
        io.out_ready = 1'b1;
        send(2'b01, 32'h40A00000, 32'h3F800000, 4'd0);
        send(2'b10, 32'h40000000, 32'h40400000, 4'd1);
        send(2'b11, 32'h40C00000, 32'h40400000, 4'd2);
        wait_results(3, "each_op");
        for (int i = 0; i < 3; i++) begin
            beat_t g;
            g = (got_q.size() > i) ? got_q[i] : '0;
            vectors += 3;
            if (g.res !== er[i]) begin miscompares++; $display("FAIL each_op_res[%0d] got %h want %h", i, g.res, er[i]); end
            if (g.tag !== 4'(i)) begin miscompares++; $display("FAIL each_op_tag[%0d] got %h want %0d", i, g.tag, i); end
            if (g.op !== eo[i]) begin miscompares++; $display("FAIL each_op_op[%0d] got %b want %b", i, g.op, eo[i]); end
        end
        repeat (2) tick();
    endtask

    task automatic test_reorder();
        logic [31:0] er [2] = '{32'h40000000, 32'h40400000};
        logic [3:0]  et [2] = '{4'd1, 4'd2};
        got_q.delete();
        io.out_ready = 1'b1;
        send(2'b11, 32'h40C00000, 32'h40400000, 4'd1);
        send(2'b00, 32'h3F800000, 32'h40000000, 4'd2);
        wait_results(2, "reorder");
        for (int i = 0; i < 2; i++) begin
            beat_t g;
            g = (got_q.size() > i) ? got_q[i] : '0;
            vectors += 2;
            if (g.res !== er[i]) begin miscompares++; $display("FAIL reorder_res[%0d] got %h want %h", i, g.res, er[i]); end
            if (g.tag !== et[i]) begin miscompares++; $display("FAIL reorder_tag[%0d] got %h want %h", i, g.tag, et[i]); end
        end
        repeat (2) tick();
    endtask

    task automatic test_full();
        logic [31:0] ea [5] = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40000000, 32'h3F800000};
        logic [31:0] eb [5] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000, 32'h3F000000};
        logic [31:0] er [5] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h3FC00000};
        got_q.delete();
        io.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'b00, ea[i], eb[i], 4'(i));
        io.in_valid = 1'b1;
        io.in_op = 2'b00;
        io.in_a = ea[4];
        io.in_b = eb[4];
        io.in_tag = 4'd4;
        repeat (6) tick();
        sample();
        vectors += 3;
        if (io.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready got %b want 0", io.in_ready); end
        if (io.out_valid !== 1'b1) begin miscompares++; $display("FAIL full_out_valid got %b want 1", io.out_valid); end
        if (got_q.size() !== 0) begin miscompares++; $display("FAIL full_no_retire got %0d want 0", got_q.size()); end
        tick();
        io.out_ready = 1'b1;
        sample();
        vectors++;
        if (io.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_retire_cycle_ready got %b want 0", io.in_ready); end
        tick();
        io.out_ready = 1'b0;
        sample();
        vectors += 2;
        if (io.in_ready !== 1'b1) begin miscompares++; $display("FAIL full_after_retire_ready got %b want 1", io.in_ready); end
        if (got_q.size() !== 1) begin miscompares++; $display("FAIL full_one_retire got %0d want 1", got_q.size()); end
        tick();
        io.in_valid = 1'b0;
        io.out_ready = 1'b1;
        wait_results(5, "full");
        for (int i = 0; i < 5; i++) begin
            beat_t g;
            g = (got_q.size() > i) ? got_q[i] : '0;
            vectors += 2;
            if (g.res !== er[i]) begin miscompares++; $display("FAIL full_res[%0d] got %h want %h", i, g.res, er[i]); end
            if (g.tag !== 4'(i)) begin miscompares++; $display("FAIL full_tag[%0d] got %h want %0d", i, g.tag, i); end
        end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        // a = 1.0 .. 12.0, b = 1.0, results 2.0 .. 13.0
        logic [31:0] ea [12] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                 32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                                 32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};
        logic [31:0] er [12] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                                 32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000,
                                 32'h41200000, 32'h41300000, 32'h41400000, 32'h41500000};
        int stalls;
        got_q.delete();
        stalls = 0;
        io.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            io.in_valid = 1'b1;
            io.in_op = 2'b00;
            io.in_a = ea[i];
            io.in_b = 32'h3F800000;
            io.in_tag = 4'(i);
            sample();
            if (io.in_ready !== 1'b1) stalls++;
            tick();
        end
        io.in_valid = 1'b0;
        vectors++;
        if (stalls != 0) begin miscompares++; $display("FAIL b2b_stalls got %0d want 0", stalls); end
        wait_results(12, "b2b");
        for (int i = 0; i < 12; i++) begin
            beat_t g;
            g = (got_q.size() > i) ? got_q[i] : '0;
            vectors += 2;
            if (g.res !== er[i]) begin miscompares++; $display("FAIL b2b_res[%0d] got %h want %h", i, g.res, er[i]); end
            if (g.tag !== 4'(i)) begin miscompares++; $display("FAIL b2b_tag[%0d] got %h want %0d", i, g.tag, i); end
        end
        tick();
        sample();
        vectors++;
        if (io.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy got %b want 0", io.busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        io.out_ready = 1'b0;
        send(2'b11, 32'h40C00000, 32'h40400000, 4'd5);
        send(2'b10, 32'h40000000, 32'h40400000, 4'd6);
        send(2'b11, 32'h40C00000, 32'h40400000, 4'd7);
        reset = 1'b0;
        sample();
        vectors += 3;
        if (io.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_out_valid got %b want 0", io.out_valid); end
        if (io.busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy got %b want 0", io.busy); end
        if (io.in_ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_in_ready got %b want 1", io.in_ready); end
        tick();
        reset = 1'b1;
        got_q.delete();
        io.out_ready = 1'b1;
        repeat (10) tick();
        vectors += 2;
        if (got_q.size() !== 0) begin miscompares++; $display("FAIL mid_stale_beats got %0d want 0", got_q.size()); end
        if (io.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %b want 0", io.busy); end
`ifdef FPU_DISPATCH_STATS_EN
        vectors += 2;
        if (stall_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_stall_cnt got %0d want 0", stall_cnt); end
        if (retire_cnt !== 16'd0) begin miscompares++; $display("FAIL mid_retire_cnt got %0d want 0", retire_cnt); end
`endif
        send(2'b00, 32'h40000000, 32'h40400000, 4'd9);
        wait_results(1, "mid_new");
        repeat (3) tick();
        vectors += 3;
        if (got_q.size() !== 1) begin miscompares++; $display("FAIL mid_new_beats got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            if (got_q[0].res !== 32'h40A00000) begin miscompares++; $display("FAIL mid_new_res got %h want 40A00000", got_q[0].res); end
            if (got_q[0].tag !== 4'd9) begin miscompares++; $display("FAIL mid_new_tag got %h want 9", got_q[0].tag); end
        end else begin
            miscompares += 2;
            $display("FAIL mid_new_fields got none want one beat");
        end
`ifdef FPU_DISPATCH_STATS_EN
        vectors++;
        if (retire_cnt !== 16'd1) begin miscompares++; $display("FAIL mid_retire_cnt_after got %0d want 1", retire_cnt); end
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        io.in_valid = 1'b0;
        io.in_op = 2'b00;
        io.in_a = 32'd0;
        io.in_b = 32'd0;
        io.in_tag = 4'd0;
        io.out_ready = 1'b0;
        test_reset();
        test_single_add();
        test_each_op();
        test_reorder();
        test_full();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
